// File: rtl/apb_pkg.sv
// Shared APB types: FSM state encoding, strobe width and the command record
// that both the master and the timer register block understand.
package apb_pkg;

  localparam int APB_ADDR_W = 12;
  localparam int APB_DATA_W = 32;
  localparam int APB_STRB_W = APB_DATA_W / 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } apb_state_e;

  typedef struct packed {
    logic                  write;
    logic [APB_ADDR_W-1:0] addr;
    logic [APB_DATA_W-1:0] wdata;
    logic [APB_STRB_W-1:0] strb;
  } apb_cmd_t;

  function automatic int strb_width(input int data_w);
    return data_w / 8;
  endfunction

endpackage

// File: rtl/apb_master.sv
// APB initiator: one command at a time through SETUP/ACCESS, with a wait-state
// watchdog so a slave that never readies cannot hang the bus.
module apb_master
  import apb_pkg::*;
#(
  parameter int ADDR_W  = 12,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 16
) (
  input  logic                  sys_clk,
  input  logic                  sys_rst_n,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ADDR_W-1:0]     cmd_addr,
  input  logic [DATA_W-1:0]     cmd_wdata,
  input  logic [DATA_W/8-1:0]   cmd_strb,
  output logic                  rsp_valid,
  output logic [DATA_W-1:0]     rsp_rdata,
  output logic                  rsp_err,
  output logic                  tim_psel,
  output logic                  tim_penable,
  output logic                  tim_pwrite,
  output logic [ADDR_W-1:0]     tim_paddr,
  output logic [DATA_W-1:0]     tim_pwdata,
  output logic [DATA_W/8-1:0]   tim_pstrb,
  input  logic                  tim_pready,
  input  logic [DATA_W-1:0]     tim_prdata,
  input  logic                  tim_pslverr
);

  localparam int STRB_W = strb_width(DATA_W);
  localparam int CNT_W  = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);

  apb_state_e          state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                cmd_ready_q, cmd_ready_d;
  logic                rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0]   rsp_rdata_q, rsp_rdata_d;
  logic                rsp_err_q, rsp_err_d;
  logic                psel_q, psel_d;
  logic                penable_q, penable_d;
  logic                pwrite_q, pwrite_d;
  logic [ADDR_W-1:0]   paddr_q, paddr_d;
  logic [DATA_W-1:0]   pwdata_q, pwdata_d;
  logic [STRB_W-1:0]   pstrb_q, pstrb_d;
  logic                timeout_hit;

  // This ACCESS cycle is the TIMEOUT-th one without ready; a ready in the same cycle still wins.
  assign timeout_hit = (TIMEOUT != 0) && ((int'(cnt_q) + 1) >= TIMEOUT);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    psel_d      = psel_q;
    penable_d   = penable_q;
    pwrite_d    = pwrite_q;
    paddr_d     = paddr_q;
    pwdata_d    = pwdata_q;
    pstrb_d     = pstrb_q;

    case (state_q)
      IDLE: begin
        psel_d    = 1'b0;
        penable_d = 1'b0;
        if (cmd_valid && cmd_ready_q) begin
          state_d  = SETUP;
          psel_d   = 1'b1;
          cnt_d    = '0;
          pwrite_d = cmd_write;
          paddr_d  = cmd_addr;
          if (cmd_write) begin
            pwdata_d = cmd_wdata;
            pstrb_d  = cmd_strb;
          end else begin
            pstrb_d  = '0;
          end
        end
      end
      SETUP: begin
        state_d   = ACCESS;
        penable_d = 1'b1;
      end
      ACCESS: begin
        if (tim_pready) begin
          state_d     = IDLE;
          psel_d      = 1'b0;
          penable_d   = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_rdata_d = pwrite_q ? '0 : tim_prdata;
          rsp_err_d   = tim_pslverr;
        end else if (timeout_hit) begin
          state_d     = IDLE;
          psel_d      = 1'b0;
          penable_d   = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_rdata_d = '0;
          rsp_err_d   = 1'b1;
        end
        if (!tim_pready && (int'(cnt_q) < TIMEOUT)) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d   = IDLE;
        psel_d    = 1'b0;
        penable_d = 1'b0;
      end
    endcase

    cmd_ready_d = (state_d == IDLE);
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      cmd_ready_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
      psel_q      <= 1'b0;
      penable_q   <= 1'b0;
      pwrite_q    <= 1'b0;
      paddr_q     <= '0;
      pwdata_q    <= '0;
      pstrb_q     <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      cmd_ready_q <= cmd_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
      psel_q      <= psel_d;
      penable_q   <= penable_d;
      pwrite_q    <= pwrite_d;
      paddr_q     <= paddr_d;
      pwdata_q    <= pwdata_d;
      pstrb_q     <= pstrb_d;
    end
  end

  assign cmd_ready   = cmd_ready_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_rdata   = rsp_rdata_q;
  assign rsp_err     = rsp_err_q;
  assign tim_psel    = psel_q;
  assign tim_penable = penable_q;
  assign tim_pwrite  = pwrite_q;
  assign tim_paddr   = paddr_q;
  assign tim_pwdata  = pwdata_q;
  assign tim_pstrb   = pstrb_q;

endmodule

// File: doc/apb_master.md
Name: apb_master

Overview:
- APB initiator that drives the timer's APB slave port from a simple command/response interface (CPU-side bridge or test sequencer).
- Accepts one command at a time, runs the APB SETUP then ACCESS phases, and holds ACCESS through slave wait states.
- Returns read data and error status as a single-cycle response pulse.
- Includes a wait-state watchdog so that a slave which never asserts ready cannot hang the bus.

Parameters:
- ADDR_W, 12, width of tim_paddr and cmd_addr.
- DATA_W, 32, width of the write and read data buses; must be a multiple of 8.
- TIMEOUT, 16, maximum number of ACCESS cycles with tim_pready low before the master aborts; 0 disables the watchdog.

Ports:
- sys_clk  in  1  clock; all flops use the rising edge.
- sys_rst_n  in  1  asynchronous active-low reset.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  command accepted when cmd_valid and cmd_ready are both high in the same cycle.
- cmd_write  in  1  1 = write, 0 = read.
- cmd_addr  in  ADDR_W  transfer address.
- cmd_wdata  in  DATA_W  write data.
- cmd_strb  in  DATA_W/8  write byte strobes.
- rsp_valid  out  1  one-cycle response pulse; there is no backpressure.
- rsp_rdata  out  DATA_W  read data; valid with rsp_valid on reads.
- rsp_err  out  1  slave error or timeout; valid with rsp_valid.
- tim_psel  out  1  APB select.
- tim_penable  out  1  APB enable.
- tim_pwrite  out  1  APB direction.
- tim_paddr  out  ADDR_W  APB address.
- tim_pwdata  out  DATA_W  APB write data.
- tim_pstrb  out  DATA_W/8  APB strobes.
- tim_pready  in  1  slave ready.
- tim_prdata  in  DATA_W  slave read data.
- tim_pslverr  in  1  slave error.

Behaviour:
- Clock and reset: single clock sys_clk; sys_rst_n is asynchronous and active-low.
- Reset values: all outputs are 0 (cmd_ready, rsp_valid, rsp_err, rsp_rdata, all tim_* outputs). The FSM state is IDLE and the wait counter is 0. cmd_ready rises to 1 in the first cycle after reset deassertion.
- FSM states: IDLE, SETUP, ACCESS.
- IDLE:
  - cmd_ready = 1; tim_psel = 0; tim_penable = 0.
  - On cmd_valid, register cmd_write/addr/wdata/strb into tim_pwrite/paddr/pwdata/pstrb and go to SETUP.
  - For reads, tim_pstrb is forced to 0 and tim_pwdata is held at the last value.
- SETUP (exactly one cycle):
  - tim_psel = 1, tim_penable = 0, cmd_ready = 0.
  - Always go to ACCESS.
- ACCESS:
  - tim_psel = 1, tim_penable = 1.
  - Address, control and write data stay stable until the state is left.
  - Wait counter increments each ACCESS cycle in which tim_pready = 0.
- Completion: tim_pready = 1 sampled in ACCESS.
  - Next cycle: rsp_valid = 1; rsp_rdata = tim_prdata (reads) or 0 (writes); rsp_err = tim_pslverr.
  - State returns to IDLE; tim_psel and tim_penable drop to 0.
- Timeout: TIMEOUT != 0 and the wait counter reaches TIMEOUT while tim_pready is still 0.
  - Next cycle: rsp_valid = 1, rsp_err = 1, rsp_rdata = 0; return to IDLE with psel/penable = 0.
  - If tim_pready = 1 in the same cycle the counter reaches TIMEOUT, this counts as normal completion; the ready wins.
- Response lifetime: rsp_valid is high for exactly one cycle. rsp_rdata and rsp_err hold their values until the next response.
- Throughput: no back-to-back pipelining. Minimum 3 cycles per transfer with a zero-wait slave (IDLE accept, SETUP, ACCESS).
- Latency example: the timer slave inserts one wait state. A command accepted at cycle N gives SETUP at N+1, ACCESS at N+2..N+3, rsp_valid at N+4, and cmd_ready high again at N+4.
- Inputs outside a transfer: cmd_valid during SETUP or ACCESS is ignored; cmd_ready = 0 and the command is not consumed. tim_pready and tim_pslverr outside ACCESS are ignored.
- Reset mid-transfer: the bus is dropped immediately (psel/penable = 0) and no response is issued.
- Width rules: wait counter width is clog2(TIMEOUT+1), minimum 1; it saturates at TIMEOUT and clears on entry to SETUP.

Decomposition:
- Shared package apb_pkg holds:
  - the FSM state enum (IDLE/SETUP/ACCESS);
  - the DATA_W/8 strobe-width constant;
  - a command struct (write, addr, wdata, strb) that is reused by the timer register block.
- No sub-module. The watchdog counter stays inline because it is tightly coupled to the FSM.

Test Plan:
- Write with the timer slave (one wait state): cmd write addr 0x004, wdata 0xDEADBEEF, strb 0xF.
  - Required: psel high for 3 cycles, penable high for 2, paddr/pwdata stable throughout, rsp_valid at N+4, rsp_err = 0.
- Read, zero-wait slave model: addr 0x010, slave returns 0x12345678.
  - Required: rsp_valid at N+3, rsp_rdata = 0x12345678, tim_pstrb = 0 during the transfer.
- Slave error: pslverr = 1 together with pready on a write.
  - Required: rsp_err = 1 for one pulse; the next command completes with rsp_err = 0.
- Timeout: TIMEOUT = 4, slave never readies.
  - Required: exactly 4 ACCESS cycles, then psel = 0, rsp_valid = 1, rsp_err = 1, rsp_rdata = 0.
  - Repeat with pready = 1 on the 4th ACCESS cycle: normal completion, rsp_err = 0.
- Reset and command hold: assert sys_rst_n = 0 during ACCESS.
  - Required: psel, penable and rsp_valid go to 0 asynchronously with no response pulse; cmd_ready = 1 on the first cycle after release.
  - cmd_valid held through a busy transfer is accepted only when the FSM is back in IDLE.
